// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot row drive, column sync,
// per-frame ghost rejection and frame-based debounce.
module keypad_scanner #(
  parameter int SCAN_TICKS      = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int CW =
    (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_FRAMES - 1);

  logic [3:0]    r_col_s1;
  logic [3:0]    r_col_s2;
  logic [TW-1:0] r_tick;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_row_drive;
  logic [7:0]    r_hit;
  logic          r_hit_seen;
  logic          r_multi;
  logic [7:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_key_row;
  logic [3:0]    r_key_col;
  logic          r_valid;
  logic          r_press;
  logic          r_release;

  logic          w_sample;
  logic          w_frame_end;
  logic          w_col_any;
  logic          w_col_one;
  logic          w_multi;
  logic          w_seen;
  logic [7:0]    w_hit;
  logic [7:0]    w_frame_code;
  logic [7:0]    w_stable;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_commit;

  assign w_sample    = (r_tick == TICK_LAST);
  assign w_frame_end = w_sample && (r_row_idx == 2'd3);
  assign w_col_any   = |r_col_s2;
  assign w_col_one   = w_col_any &&
    ((r_col_s2 & (r_col_s2 - 4'd1)) == 4'd0);

  // A second hit in the frame, or several columns at once,
  // means ghosting or a multi-key press.
  assign w_multi = r_multi
                 | (w_col_one & r_hit_seen)
                 | (w_col_any & ~w_col_one);
  assign w_seen  = r_hit_seen | w_col_one;
  assign w_hit   = w_col_one ? {r_row_drive, r_col_s2} : r_hit;

  assign w_frame_code =
    (w_seen && !w_multi) ? w_hit : 8'h00;
  assign w_stable = {r_key_row, r_key_col};

  assign w_cnt_nxt =
    (w_frame_code != r_cand) ? '0 :
    (r_cnt == CNT_LAST)      ? r_cnt :
                               r_cnt + CW'(1);
  assign w_commit = (w_cnt_nxt == CNT_LAST) &&
                    (w_frame_code != w_stable);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_s1    <= '0;
      r_col_s2    <= '0;
      r_tick      <= '0;
      r_row_idx   <= '0;
      r_row_drive <= 4'b0001;
      r_hit       <= '0;
      r_hit_seen  <= 1'b0;
      r_multi     <= 1'b0;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_key_row   <= '0;
      r_key_col   <= '0;
      r_valid     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      r_col_s1  <= col_in;
      r_col_s2  <= r_col_s1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_sample) begin
        r_tick      <= '0;
        r_row_idx   <= r_row_idx + 2'd1;
        r_row_drive <= {r_row_drive[2:0], r_row_drive[3]};
        if (w_frame_end) begin
          r_hit      <= '0;
          r_hit_seen <= 1'b0;
          r_multi    <= 1'b0;
          r_cand     <= w_frame_code;
          r_cnt      <= w_cnt_nxt;
          if (w_commit) begin
            r_key_row <= w_frame_code[7:4];
            r_key_col <= w_frame_code[3:0];
            r_valid   <= (w_frame_code != 8'h00);
            r_press   <= (w_frame_code != 8'h00);
            r_release <= (w_frame_code == 8'h00);
          end
        end else begin
          r_hit      <= w_hit;
          r_hit_seen <= w_seen;
          r_multi    <= w_multi;
        end
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end
  end

  assign row_drive   = r_row_drive;
  assign key_row     = r_key_row;
  assign key_col     = r_key_col;
  assign key_valid   = r_valid;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural
// 4x4 key matrix driving col_in from row_drive.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_drive;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       key_valid;
  logic       key_press;
  logic       key_release;

  logic [3:0] keymap [4];
  int errs;
  int checks;
  int press_cnt;
  int rel_cnt;
  int both_cnt;

  keypad_scanner #(
    .SCAN_TICKS(4),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_in(col_in),
    .row_drive(row_drive),
    .key_row(key_row),
    .key_col(key_col),
    .key_valid(key_valid),
    .key_press(key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col_in = 4'b0000;
    for (int r = 0; r < 4; r++)
      if (row_drive[r]) col_in = col_in | keymap[r];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (key_press) press_cnt++;
      if (key_release) rel_cnt++;
      if (key_press && key_release) both_cnt++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (16 * n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clr_keys();
    for (int r = 0; r < 4; r++) keymap[r] = 4'b0000;
  endtask

  task automatic clr_cnt();
    press_cnt = 0;
    rel_cnt   = 0;
  endtask

  logic [3:0] exp_rd;

  initial begin
    errs = 0;
    checks = 0;
    both_cnt = 0;
    clr_cnt();
    clr_keys();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_row_drive", 32'(row_drive), 32'h1);
    chk("rst_keys", 32'({key_row, key_col}), 32'h0);
    chk("rst_flags",
        32'({key_valid, key_press, key_release}), 32'h0);

    rst = 1'b0;
    keymap[1] = 4'b0010;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("midscan_rst_drive", 32'(row_drive), 32'h1);
    chk("midscan_rst_valid", 32'(key_valid), 32'h0);
    clr_keys();
    rst = 1'b0;

    exp_rd = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      exp_rd = {exp_rd[2:0], exp_rd[3]};
      chk("rotate", 32'(row_drive), 32'(exp_rd));
    end

    clr_cnt();
    keymap[1] = 4'b0010;
    frames(2);
    chk("press_f2_valid", 32'(key_valid), 32'h0);
    frames(1);
    chk("press_row", 32'(key_row), 32'h2);
    chk("press_col", 32'(key_col), 32'h2);
    chk("press_valid", 32'(key_valid), 32'h1);
    chk("press_pulse", 32'(press_cnt), 32'd1);
    frames(10);
    chk("hold_press_cnt", 32'(press_cnt), 32'd1);
    chk("hold_rel_cnt", 32'(rel_cnt), 32'd0);
    chk("hold_keys", 32'({key_row, key_col}), 32'h22);

    clr_cnt();
    clr_keys();
    frames(2);
    chk("rel_f2_valid", 32'(key_valid), 32'h1);
    frames(1);
    chk("rel_keys", 32'({key_row, key_col}), 32'h0);
    chk("rel_valid", 32'(key_valid), 32'h0);
    chk("rel_pulse", 32'(rel_cnt), 32'd1);
    chk("rel_no_press", 32'(press_cnt), 32'd0);

    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      keymap[1] = 4'b0010;
      frames(2);
      keymap[1] = 4'b0000;
      frames(1);
    end
    chk("bounce_valid", 32'(key_valid), 32'h0);
    chk("bounce_press", 32'(press_cnt), 32'd0);
    chk("bounce_rel", 32'(rel_cnt), 32'd0);

    clr_cnt();
    keymap[2] = 4'b0001;
    frames(3);
    chk("k20_keys", 32'({key_row, key_col}), 32'h41);
    keymap[2] = 4'b0101;
    frames(2);
    chk("multi_f2_valid", 32'(key_valid), 32'h1);
    frames(1);
    chk("multi_rel_valid", 32'(key_valid), 32'h0);
    chk("multi_rel_cnt", 32'(rel_cnt), 32'd1);
    chk("multi_press_cnt", 32'(press_cnt), 32'd1);

    clr_cnt();
    clr_keys();
    keymap[0] = 4'b0001;
    keymap[3] = 4'b1000;
    frames(4);
    chk("tworow_valid", 32'(key_valid), 32'h0);
    chk("tworow_press", 32'(press_cnt), 32'd0);

    clr_keys();
    keymap[0] = 4'b1000;
    frames(3);
    chk("roll_a_keys", 32'({key_row, key_col}), 32'h18);
    clr_cnt();
    clr_keys();
    keymap[3] = 4'b0001;
    frames(2);
    chk("roll_f2_keys", 32'({key_row, key_col}), 32'h18);
    frames(1);
    chk("roll_row", 32'(key_row), 32'h8);
    chk("roll_col", 32'(key_col), 32'h1);
    chk("roll_valid", 32'(key_valid), 32'h1);
    chk("roll_press", 32'(press_cnt), 32'd1);
    chk("roll_no_rel", 32'(rel_cnt), 32'd0);
    chk("never_both", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
